// File: rtl/sram_1rw1r_wmask.sv
// ---------------------------------------------------------------------------
// sram_1rw1r_wmask
//
// Behavioural one-read-write plus one-read SRAM with a per-byte write mask.
// All port inputs are registered on the rising edge of clk. The array
// operation for those captured values runs on the following falling edge.
// With OUT_REG=1 the read results are re-registered on the next rising
// edge.
//
// Parameters
//   DATA_WIDTH : word width in bits, multiple of 8
//   ADDR_WIDTH : address width of both ports
//   DEPTH      : number of words, DEPTH <= 2**ADDR_WIDTH
//   OUT_REG    : 1 adds a rising-edge output stage on dout/rvalid/collision
//
// Ports
//   clk        : single clock
//   rst        : asynchronous active-high reset (array contents untouched)
//   csb0       : port 0 chip select, active low
//   web0       : port 0 write enable, active low
//   wmask0     : port 0 byte write mask, bit i enables din0 byte i
//   addr0      : port 0 address
//   din0       : port 0 write data
//   dout0      : port 0 read data, holds between reads
//   rvalid0    : dout0 carries data from a read in this interval
//   csb1       : port 1 chip select, active low
//   addr1      : port 1 address
//   dout1      : port 1 read data, holds between reads
//   rvalid1    : dout1 carries data from a read in this interval
//   collision  : same-address port 0 write / port 1 read in this interval
//   addr_err   : sticky, set by any enabled access with address >= DEPTH
// ---------------------------------------------------------------------------
module sram_1rw1r_wmask #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter bit OUT_REG    = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    csb0,
    input  logic                    web0,
    input  logic [DATA_WIDTH/8-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]   addr0,
    input  logic [DATA_WIDTH-1:0]   din0,
    output logic [DATA_WIDTH-1:0]   dout0,
    output logic                    rvalid0,
    input  logic                    csb1,
    input  logic [ADDR_WIDTH-1:0]   addr1,
    output logic [DATA_WIDTH-1:0]   dout1,
    output logic                    rvalid1,
    output logic                    collision,
    output logic                    addr_err
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    // -----------------------------------------------------------------------
    // Storage. Deliberately has no reset and no initial contents.
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // -----------------------------------------------------------------------
    // Input capture registers (rising edge, every cycle).
    // Reset parks both ports deselected so an operation captured before a
    // reset pulse is cancelled at the falling edge.
    // -----------------------------------------------------------------------
    logic                  q_csb0;
    logic                  q_web0;
    logic [NUM_BYTES-1:0]  q_wmask0;
    logic [ADDR_WIDTH-1:0] q_addr0;
    logic [DATA_WIDTH-1:0] q_din0;
    logic                  q_csb1;
    logic [ADDR_WIDTH-1:0] q_addr1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_csb0   <= 1'b1;
            q_web0   <= 1'b1;
            q_wmask0 <= '0;
            q_addr0  <= '0;
            q_din0   <= '0;
            q_csb1   <= 1'b1;
            q_addr1  <= '0;
        end else begin
            q_csb0   <= csb0;
            q_web0   <= web0;
            q_wmask0 <= wmask0;
            q_addr0  <= addr0;
            q_din0   <= din0;
            q_csb1   <= csb1;
            q_addr1  <= addr1;
        end
    end

    // -----------------------------------------------------------------------
    // Operation decode from the captured values only.
    // -----------------------------------------------------------------------
    logic                  rd0_op;
    logic                  wr0_op;
    logic                  rd1_op;
    logic                  in_range0;
    logic                  in_range1;
    logic                  col_evt;
    logic                  err_evt;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;

    always_comb begin
        rd0_op    = ~q_csb0 & q_web0;
        // An all-zero mask is still a write: it suppresses the port 0 read.
        wr0_op    = ~q_csb0 & ~q_web0;
        rd1_op    = ~q_csb1;
        in_range0 = ({1'b0, q_addr0} < DEPTH_LIM);
        in_range1 = ({1'b0, q_addr1} < DEPTH_LIM);
        col_evt   = wr0_op & rd1_op & in_range0 & (q_addr0 == q_addr1);
        err_evt   = (~q_csb0 & ~in_range0) | (rd1_op & ~in_range1);
        // Out-of-range reads return zero rather than touching the array.
        rdata0    = in_range0 ? mem[q_addr0] : '0;
        rdata1    = in_range1 ? mem[q_addr1] : '0;
    end

    // -----------------------------------------------------------------------
    // Array write (falling edge). The read path samples mem in the same
    // edge, so a colliding port 1 read sees the pre-write word.
    // -----------------------------------------------------------------------
    always_ff @(negedge clk) begin
        if (wr0_op && in_range0) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (q_wmask0[b]) begin
                    mem[q_addr0][b*8 +: 8] <= q_din0[b*8 +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Falling-edge read results and status.
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] dout0_n;
    logic [DATA_WIDTH-1:0] dout1_n;
    logic                  rvalid0_n;
    logic                  rvalid1_n;
    logic                  collision_n;
    logic                  addr_err_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            dout0_n     <= '0;
            dout1_n     <= '0;
            rvalid0_n   <= 1'b0;
            rvalid1_n   <= 1'b0;
            collision_n <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            rvalid0_n   <= rd0_op;
            rvalid1_n   <= rd1_op;
            collision_n <= col_evt;
            if (rd0_op) begin
                dout0_n <= rdata0;
            end
            if (rd1_op) begin
                dout1_n <= rdata1;
            end
            if (err_evt) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    // addr_err is a status flag, not read data, so it skips the output stage.
    assign addr_err = addr_err_q;

    // -----------------------------------------------------------------------
    // Optional rising-edge output stage.
    // -----------------------------------------------------------------------
    generate
        if (OUT_REG) begin : g_out_reg
            logic [DATA_WIDTH-1:0] dout0_r;
            logic [DATA_WIDTH-1:0] dout1_r;
            logic                  rvalid0_r;
            logic                  rvalid1_r;
            logic                  collision_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout0_r     <= '0;
                    dout1_r     <= '0;
                    rvalid0_r   <= 1'b0;
                    rvalid1_r   <= 1'b0;
                    collision_r <= 1'b0;
                end else begin
                    dout0_r     <= dout0_n;
                    dout1_r     <= dout1_n;
                    rvalid0_r   <= rvalid0_n;
                    rvalid1_r   <= rvalid1_n;
                    collision_r <= collision_n;
                end
            end

            assign dout0     = dout0_r;
            assign dout1     = dout1_r;
            assign rvalid0   = rvalid0_r;
            assign rvalid1   = rvalid1_r;
            assign collision = collision_r;
        end else begin : g_no_out_reg
            assign dout0     = dout0_n;
            assign dout1     = dout1_n;
            assign rvalid0   = rvalid0_n;
            assign rvalid1   = rvalid1_n;
            assign collision = collision_n;
        end
    endgenerate

endmodule
